inst_encoder_loader: RTL and testbench

//  Inverse of the instruction field decoder: accepts decoded RV32I fields (opcode[6:2], func3,

---
 rtl/inst_encoder_loader_pkg.sv | 33 +++
 rtl/inst_encoder_loader_packer.sv | 39 +++
 rtl/inst_encoder_loader.sv | 135 +++++++++++++
 tb/tb_inst_encoder_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_loader_pkg.sv
// Shared RV32I encoding definitions: format codes, opcode[6:2] values, NOP word
// and the loader FSM states.
package inst_encoder_loader_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // inst[6:2]; inst[1:0] is always 2'b11 for 32-bit encodings
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/inst_encoder_loader_packer.sv
// Combinational re-packer: decoded RV32I fields plus format -> 32-bit instruction word.
// Unknown formats produce a NOP and raise err_o.
module inst_field_packer
  import inst_encoder_loader_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [4:0]  opcode_i,
  input  logic [2:0]  func3_i,
  input  logic [6:0]  func7_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        err_o
);

  logic [6:0] op7;
  assign op7 = {opcode_i, 2'b11};

  always_comb begin
    word_o = NOP_WORD;
    err_o  = 1'b0;
    case (fmt_i)
      FMT_R: word_o = {func7_i, rs2_i, rs1_i, func3_i, rd_i, op7};
      FMT_I: word_o = {imm_i[11:0], rs1_i, func3_i, rd_i, op7};
      FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, func3_i, imm_i[4:0], op7};
      FMT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, func3_i,
                       imm_i[4:1], imm_i[11], op7};
      FMT_U: word_o = {imm_i[31:12], rd_i, op7};
      FMT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op7};
      default: begin
        word_o = NOP_WORD;
        err_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder_loader.sv
// Program loader: accepts decoded field tuples over valid/ready, encodes them and
// streams the words sequentially into IMEM through a single output register.
module inst_encoder_loader
  import inst_encoder_loader_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_opcode,
  input  logic [2:0]        in_func3,
  input  logic [6:0]        in_func7,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic              fmt_err,
  output logic [ADDR_W-3:0] words,
  output logic [1:0]        dbg_state
);

  // Handshakes: a tuple transfers on the rising edge where in_valid & in_ready;
  // an IMEM write completes on the rising edge where imem_we & imem_ready, and
  // imem_we/addr/wdata never change while imem_we is high and imem_ready is low.

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-3:0] words_q, words_d;

  logic [31:0] pack_word;
  logic        pack_err;
  logic        write_done;
  logic        accept;

  inst_field_packer u_packer (
    .fmt_i    (in_fmt),
    .opcode_i (in_opcode),
    .func3_i  (in_func3),
    .func7_i  (in_func7),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .rd_i     (in_rd),
    .imm_i    (in_imm),
    .word_o   (pack_word),
    .err_o    (pack_err)
  );

  assign write_done = we_q & imem_ready;
  assign in_ready   = (state_q == ST_LOAD) & ~last_q & (~we_q | imem_ready);
  assign accept     = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    words_d = words_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = {start_addr[ADDR_W-1:2], 2'b00};
          words_d = '0;
          err_d   = 1'b0;
          last_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (write_done) begin
          we_d    = 1'b0;
          addr_d  = addr_q + ADDR_W'(4);
          words_d = words_q + 1'b1;
          // once the last tuple is taken, the write completing now is the final one
          if (last_q) state_d = ST_DONE;
        end
        if (accept) begin
          we_d    = 1'b1;
          wdata_d = pack_word;
          err_d   = err_q | pack_err;
          if (in_last) last_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      words_q <= words_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign fmt_err    = err_q;
  assign words      = words_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: directed sessions on a 16-bit and a 4-bit address
// instance, checked every cycle against a transaction-level model.
module tb_inst_encoder_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] start_addr;
  logic        in_valid;
  logic [2:0]  in_fmt;
  logic [4:0]  in_opcode;
  logic [2:0]  in_func3;
  logic [6:0]  in_func7;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic        in_last;
  logic        imem_ready;

  logic        in_ready, imem_we, busy, done, fmt_err;
  logic [15:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [13:0] words;
  logic [1:0]  dbg_state;

  logic        in_ready4, imem_we4, busy4, done4, fmt_err4;
  logic [3:0]  imem_addr4;
  logic [31:0] imem_wdata4;
  logic [1:0]  words4;
  logic [1:0]  dbg_state4;

  int checks;
  int failures;
  int done_cnt;

  // model state
  logic [31:0] exp_q[$];
  logic [31:0] last_wd;
  logic [15:0] base;
  int          completed;
  int          phase;
  logic        last_seen;
  logic        m_err;

  inst_encoder_loader #(.ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_func3(in_func3), .in_func7(in_func7), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ready(imem_ready),
    .busy(busy), .done(done), .fmt_err(fmt_err), .words(words), .dbg_state(dbg_state)
  );

  inst_encoder_loader #(.ADDR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr[3:0]),
    .in_valid(in_valid), .in_ready(in_ready4), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_func3(in_func3), .in_func7(in_func7), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last), .imem_we(imem_we4),
    .imem_addr(imem_addr4), .imem_wdata(imem_wdata4), .imem_ready(imem_ready),
    .busy(busy4), .done(done4), .fmt_err(fmt_err4), .words(words4), .dbg_state(dbg_state4)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Field placement written from the instruction-format tables with shifts and masks.
  function automatic logic [31:0] model_enc(input logic [31:0] fmt, input logic [31:0] op,
                                            input logic [31:0] f3, input logic [31:0] f7,
                                            input logic [31:0] rs1, input logic [31:0] rs2,
                                            input logic [31:0] rd, input logic [31:0] imm);
    logic [31:0] lo;
    logic [31:0] mid;
    lo  = (op << 2) | 32'd3;
    mid = (rs1 << 15) | (f3 << 12);
    case (fmt)
      0: return (f7 << 25) | (rs2 << 20) | mid | (rd << 7) | lo;
      1: return ((imm & 32'hFFF) << 20) | mid | (rd << 7) | lo;
      2: return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | mid | ((imm & 32'h1F) << 7) | lo;
      3: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) | mid |
                (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | lo;
      4: return (imm & 32'hFFFF_F000) | (rd << 7) | lo;
      5: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | lo;
      default: return 32'h0000_0013;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    last_wd   = 32'h0;
    base      = 16'h0;
    completed = 0;
    phase     = 0;
    last_seen = 1'b0;
    m_err     = 1'b0;
  endtask

  // scoreboard / compare process: inputs settle 1ns after posedge, so the
  // falling edge sees the exact values the next rising edge will act on
  initial begin
    logic        e_we, e_rdy, acc;
    logic [31:0] e_wd, enc;
    logic [15:0] e_addr;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      e_we   = (exp_q.size() != 0);
      e_wd   = e_we ? exp_q[0] : last_wd;
      e_addr = 16'(base + 16'(completed * 4));
      e_rdy  = (phase == 1) && !last_seen && (!e_we || imem_ready);

      chk("busy", busy, phase != 0);
      chk("done", done, phase == 2);
      chk("in_ready", in_ready, e_rdy);
      chk("imem_we", imem_we, e_we);
      chk("imem_addr", imem_addr, e_addr);
      chk("imem_wdata", imem_wdata, e_wd);
      chk("words", words, completed % 16384);
      chk("fmt_err", fmt_err, m_err);
      chk("busy4", busy4, phase != 0);
      chk("done4", done4, phase == 2);
      chk("in_ready4", in_ready4, e_rdy);
      chk("imem_we4", imem_we4, e_we);
      chk("imem_addr4", imem_addr4, e_addr[3:0]);
      chk("imem_wdata4", imem_wdata4, e_wd);
      chk("words4", words4, completed % 4);
      chk("fmt_err4", fmt_err4, m_err);
      if (done) done_cnt++;

      if (rst_n) begin
        acc = in_valid && e_rdy;
        case (phase)
          0: if (start) begin
            phase     = 1;
            base      = {start_addr[15:2], 2'b00};
            completed = 0;
            m_err     = 1'b0;
            last_seen = 1'b0;
          end
          1: begin
            if (e_we && imem_ready) begin
              void'(exp_q.pop_front());
              completed++;
              if (last_seen && exp_q.size() == 0) phase = 2;
            end
            if (acc) begin
              enc = model_enc(32'(in_fmt), 32'(in_opcode), 32'(in_func3), 32'(in_func7),
                              32'(in_rs1), 32'(in_rs2), 32'(in_rd), in_imm);
              exp_q.push_back(enc);
              last_wd = enc;
              if (in_fmt > 3'd5) m_err = 1'b1;
              if (in_last) last_seen = 1'b1;
            end
          end
          default: phase = 0;
        endcase
      end
    end
  end

  // driver tasks
  task automatic do_start(input logic [15:0] a);
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = a;
    done_cnt   = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic set_fields(input logic [2:0] fmt, input logic [4:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] imm, input logic last);
    in_fmt    = fmt;
    in_opcode = op;
    in_func3  = f3;
    in_func7  = f7;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_rd     = rd;
    in_imm    = imm;
    in_last   = last;
    in_valid  = 1'b1;
  endtask

  // returns 1ns after the edge on which the tuple was accepted
  task automatic send(input logic [2:0] fmt, input logic [4:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [31:0] imm, input logic last);
    int n;
    set_fields(fmt, op, f3, f7, rs1, rs2, rd, imm, last);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    chk("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    chk("idle_timeout", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    done_cnt   = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = 16'h0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    imem_ready = 1'b1;
    set_fields(3'd0, 5'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    in_valid = 1'b0;

    // model pinned to hand-encoded words (unused fields deliberately non-zero)
    chk("pin_R", model_enc(0, 32'h0C, 0, 0, 1, 2, 3, 32'hFFFF_FFFF), 32'h0020_81B3);
    chk("pin_I", model_enc(1, 32'h04, 0, 32'h7F, 0, 31, 1, 5), 32'h0050_0093);
    chk("pin_S", model_enc(2, 32'h08, 2, 0, 1, 2, 0, 8), 32'h0020_A423);
    chk("pin_U", model_enc(4, 32'h0D, 7, 0, 3, 0, 5, 32'h1234_5000), 32'h1234_52B7);
    chk("pin_B", model_enc(3, 32'h18, 0, 0, 0, 0, 0, 32'hFFFF_FFFC), 32'hFE00_0EE3);
    chk("pin_J", model_enc(5, 32'h1B, 0, 0, 0, 0, 1, 32'h0000_0800), 32'h0010_00EF);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", imem_we, 1'b0);
    chk("rst_addr", imem_addr, 16'h0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // session 1: one of each format, back to back
    do_start(16'h0000);
    send(3'd0, 5'b01100, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF, 1'b0);
    chk("r_we", imem_we, 1'b1);
    chk("r_addr", imem_addr, 16'h0000);
    chk("r_wdata", imem_wdata, 32'h0020_81B3);
    send(3'd1, 5'b00100, 3'd0, 7'h7F, 5'd0, 5'd31, 5'd1, 32'd5, 1'b0);
    chk("i_wdata", imem_wdata, 32'h0050_0093);
    send(3'd2, 5'b01000, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8, 1'b0);
    chk("s_wdata", imem_wdata, 32'h0020_A423);
    send(3'd4, 5'b01101, 3'd7, 7'd0, 5'd3, 5'd0, 5'd5, 32'h1234_5000, 1'b0);
    chk("u_wdata", imem_wdata, 32'h1234_52B7);
    send(3'd3, 5'b11000, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0);
    chk("b_wdata", imem_wdata, 32'hFE00_0EE3);
    send(3'd5, 5'b11011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h0000_0800, 1'b1);
    chk("j_wdata", imem_wdata, 32'h0010_00EF);
    chk("j_addr", imem_addr, 16'h0014);
    wait_idle();
    chk("s1_words", words, 14'd6);

    // session 2: IMEM back-pressure for 3 cycles with a tuple waiting
    do_start(16'h0100);
    send(3'd1, 5'b00100, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5, 1'b0);
    imem_ready = 1'b0;
    set_fields(3'd0, 5'b01100, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_we", imem_we, 1'b1);
      chk("stall_addr", imem_addr, 16'h0100);
      chk("stall_wdata", imem_wdata, 32'h0050_0093);
    end
    @(posedge clk);
    #1;
    imem_ready = 1'b1;
    send(3'd0, 5'b01100, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
    chk("stall_next_addr", imem_addr, 16'h0104);
    chk("stall_next_wdata", imem_wdata, 32'h0020_81B3);
    wait_idle();
    chk("s2_words", words, 14'd2);

    // session 3: unaligned start, 4-bit address wrap, invalid format
    do_start(16'h000E);
    send(3'd0, 5'b01100, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    chk("wrap_addr4_first", imem_addr4, 4'hC);
    chk("wrap_addr_first", imem_addr, 16'h000C);
    send(3'd6, 5'b01100, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
    chk("wrap_addr4_second", imem_addr4, 4'h0);
    chk("wrap_addr_second", imem_addr, 16'h0010);
    chk("bad_fmt_nop", imem_wdata, 32'h0000_0013);
    wait_idle();
    chk("fmt_err_set", fmt_err, 1'b1);
    chk("fmt_err4_set", fmt_err4, 1'b1);

    // session 4: reset while a write is held
    do_start(16'h0040);
    chk("fmt_err_cleared", fmt_err, 1'b0);
    send(3'd1, 5'b00100, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5, 1'b0);
    imem_ready = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", imem_we, 1'b0);
    chk("mid_rst_addr", imem_addr, 16'h0);
    chk("mid_rst_wdata", imem_wdata, 32'h0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_words", words, 14'd0);
    chk("mid_rst_done", done, 1'b0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    imem_ready = 1'b1;

    // session 5: restart after reset
    do_start(16'h0020);
    send(3'd5, 5'b11011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h0000_0800, 1'b1);
    chk("restart_addr", imem_addr, 16'h0020);
    chk("restart_wdata", imem_wdata, 32'h0010_00EF);
    wait_idle();
    chk("restart_words", words, 14'd1);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=<200000", $time);
    $fatal(1);
  end

endmodule
